reg_fault_monitor: RTL and testbench

- Downstream consumer of the laser-target register bank: watches the N_REGS target flops (same clock) against a golden pattern captured at arm time.
- Detects laser-induced bit flips, timestamps the first fault, counts fault events, and emits one {timestamp, mask} record per event over a valid/ready handshake to the host readout path.

---
 rtl/reg_fault_monitor_pkg.sv | 22 ++
 rtl/fault_rec_buf.sv | 52 +++++
 rtl/reg_fault_monitor.sv | 159 +++++++++++++++
 tb/tb_reg_fault_monitor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_fault_monitor_pkg.sv
// Shared types and constants for the register-bank fault monitor.
// Covers the FSM encoding, default widths and readout record sizing.
package reg_fault_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MONITOR = 2'd2
    } state_e;

    localparam int DEF_N_REGS = 3;
    localparam int DEF_CNT_W  = 16;
    localparam int DEF_TS_W   = 32;

    function automatic int rec_width(input int ts_w, input int n_regs);
        return ts_w + n_regs;
    endfunction

    // Packed {timestamp, mask} record width seen by the readout packer.
    localparam int REC_W = rec_width(DEF_TS_W, DEF_N_REGS);

endpackage

// File: rtl/fault_rec_buf.sv
// Single-entry valid/ready holding register for fault records.
// A load is accepted when the slot is empty or drains in the same cycle; otherwise it is dropped.
module fault_rec_buf
    import reg_fault_monitor_pkg::*;
#(
    parameter int W = REC_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         drop_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         accept;

    assign accept = valid_q && ready_i;
    assign drop_o = load_i && valid_q && !ready_i;

    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i && (!valid_q || accept)) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state updates use <= so all flops sample together; the data register is reset
    // too because the record outputs must read zero straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/reg_fault_monitor.sv
// Watches a laser-target register bank against a golden pattern captured at arm time,
// timestamps and counts bit-flip events and hands one record per event to the host.
module reg_fault_monitor
    import reg_fault_monitor_pkg::*;
#(
    parameter int N_REGS     = DEF_N_REGS,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int TS_W       = DEF_TS_W,
    parameter int SETTLE_CYC = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              disarm,
    input  logic              clear,
    input  logic [N_REGS-1:0] golden,
    input  logic [N_REGS-1:0] obs,
    output logic              busy,
    output logic              fault_flag,
    output logic [N_REGS-1:0] first_mask,
    output logic [TS_W-1:0]   first_ts,
    output logic [CNT_W-1:0]  fault_count,
    output logic              overflow,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [TS_W-1:0]   rec_ts,
    output logic [N_REGS-1:0] rec_mask
);

    localparam int         RW          = rec_width(TS_W, N_REGS);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

    state_e            state_q, state_d;
    logic [N_REGS-1:0] obs_q;
    logic [N_REGS-1:0] golden_q, golden_d;
    logic [N_REGS-1:0] prev_mm_q, prev_mm_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [7:0]        settle_q, settle_d;
    logic              flag_q, flag_d;
    logic [N_REGS-1:0] first_mask_q, first_mask_d;
    logic [TS_W-1:0]   first_ts_q, first_ts_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;

    logic [N_REGS-1:0] mm;
    logic              evt;
    logic              rec_drop;
    logic [RW-1:0]     rec_data;

    assign mm  = obs_q ^ golden_q;
    // A steady fault is one event; only a changed nonzero mask counts again.
    assign evt = (state_q == ST_MONITOR) && (mm != '0) && (mm != prev_mm_q);

    always_comb begin
        state_d   = state_q;
        golden_d  = golden_q;
        prev_mm_d = prev_mm_q;
        ts_d      = ts_q;
        settle_d  = settle_q;
        case (state_q)
            ST_IDLE: ;
            ST_SETTLE: begin
                settle_d = settle_q + 1'b1;
                if (settle_q == SETTLE_LAST) state_d = ST_MONITOR;
                if (disarm) state_d = ST_IDLE;
            end
            ST_MONITOR: begin
                prev_mm_d = mm;
                if (ts_q != {TS_W{1'b1}}) ts_d = ts_q + 1'b1;
                if (disarm) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Arm restarts the run from any state and takes priority over disarm.
        if (arm) begin
            state_d   = ST_SETTLE;
            golden_d  = golden;
            prev_mm_d = '0;
            ts_d      = '0;
            settle_d  = '0;
        end
    end

    always_comb begin
        flag_d       = flag_q;
        first_mask_d = first_mask_q;
        first_ts_d   = first_ts_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        if (clear) begin
            flag_d       = 1'b0;
            first_mask_d = '0;
            first_ts_d   = '0;
            count_d      = '0;
            overflow_d   = 1'b0;
        end
        // Applied after clear so a coincident event survives as the first of a fresh tally.
        if (evt) begin
            if (count_d != {CNT_W{1'b1}}) count_d = count_d + 1'b1;
            if (!flag_d) begin
                flag_d       = 1'b1;
                first_mask_d = mm;
                first_ts_d   = ts_q;
            end
        end
        if (rec_drop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            obs_q        <= '0;
            golden_q     <= '0;
            prev_mm_q    <= '0;
            ts_q         <= '0;
            settle_q     <= '0;
            flag_q       <= 1'b0;
            first_mask_q <= '0;
            first_ts_q   <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            obs_q        <= obs;
            golden_q     <= golden_d;
            prev_mm_q    <= prev_mm_d;
            ts_q         <= ts_d;
            settle_q     <= settle_d;
            flag_q       <= flag_d;
            first_mask_q <= first_mask_d;
            first_ts_q   <= first_ts_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
        end
    end

    fault_rec_buf #(
        .W (RW)
    ) u_rec_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (evt),
        .data_i  ({ts_q, mm}),
        .ready_i (rec_ready),
        .valid_o (rec_valid),
        .data_o  (rec_data),
        .drop_o  (rec_drop)
    );

    assign rec_ts      = rec_data[N_REGS +: TS_W];
    assign rec_mask    = rec_data[N_REGS-1:0];
    assign busy        = (state_q != ST_IDLE);
    assign fault_flag  = flag_q;
    assign first_mask  = first_mask_q;
    assign first_ts    = first_ts_q;
    assign fault_count = count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_reg_fault_monitor.sv
// Self-checking bench for reg_fault_monitor: directed corner cases, a vector table
// and randomized traffic against a run-age based reference model.
module tb_reg_fault_monitor;

    localparam int SC = 8;

    logic       clk;
    logic       reset_n;
    logic       arm, disarm, clear, rec_ready;
    logic [2:0] golden, obs;

    logic        busy, fault_flag, overflow, rec_valid;
    logic [2:0]  first_mask, rec_mask;
    logic [31:0] first_ts, rec_ts;
    logic [15:0] fault_count;

    logic        s_busy, s_flag, s_ovf, s_rv;
    logic [2:0]  s_fmask, s_rmask;
    logic [31:0] s_fts, s_rts;
    logic [1:0]  s_count;

    reg_fault_monitor u_dut (
        .clk(clk), .reset_n(reset_n), .arm(arm), .disarm(disarm), .clear(clear),
        .golden(golden), .obs(obs), .busy(busy), .fault_flag(fault_flag),
        .first_mask(first_mask), .first_ts(first_ts), .fault_count(fault_count),
        .overflow(overflow), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_ts(rec_ts), .rec_mask(rec_mask)
    );

    reg_fault_monitor #(.N_REGS(3), .CNT_W(2), .TS_W(32), .SETTLE_CYC(SC)) u_sat (
        .clk(clk), .reset_n(reset_n), .arm(arm), .disarm(disarm), .clear(clear),
        .golden(golden), .obs(obs), .busy(s_busy), .fault_flag(s_flag),
        .first_mask(s_fmask), .first_ts(s_fts), .fault_count(s_count),
        .overflow(s_ovf), .rec_valid(s_rv), .rec_ready(rec_ready),
        .rec_ts(s_rts), .rec_mask(s_rmask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a run is described by "armed" plus the number of cycles since arm.
    bit         m_armed;
    int         m_age;
    logic [2:0] m_golden, m_obs_q, m_prev, m_fmask, m_rmask;
    bit         m_flag, m_ovf, m_rv;
    longint     m_fts, m_rts;
    int         m_events;

    task automatic model_reset();
        m_armed = 0; m_age = 0; m_golden = 0; m_obs_q = 0; m_prev = 0;
        m_flag = 0; m_fmask = 0; m_fts = 0; m_events = 0; m_ovf = 0;
        m_rv = 0; m_rts = 0; m_rmask = 0;
    endtask

    task automatic model_edge();
        bit         mon, ev, acc;
        logic [2:0] mm;
        longint     ts;
        mon = m_armed && (m_age >= SC);
        ts  = mon ? longint'(m_age - SC) : 0;
        mm  = m_obs_q ^ m_golden;
        ev  = mon && (mm != 0) && (mm != m_prev);
        acc = m_rv && rec_ready;
        if (clear) begin
            m_flag = 0; m_fmask = 0; m_fts = 0; m_events = 0; m_ovf = 0;
        end
        if (ev) begin
            m_events++;
            if (!m_flag) begin m_flag = 1; m_fmask = mm; m_fts = ts; end
            if (!m_rv || acc) begin m_rv = 1; m_rts = ts; m_rmask = mm; end
            else m_ovf = 1;
        end else if (acc) begin
            m_rv = 0;
        end
        if (mon) m_prev = mm;
        if (arm) begin m_armed = 1; m_age = 0; m_golden = golden; m_prev = 0; end
        else if (disarm) m_armed = 0;
        else if (m_armed) m_age++;
        m_obs_q = obs;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".busy"},        64'(busy),        64'(m_armed));
        check({tag, ".fault_flag"},  64'(fault_flag),  64'(m_flag));
        check({tag, ".first_mask"},  64'(first_mask),  64'(m_fmask));
        check({tag, ".first_ts"},    64'(first_ts),    64'(m_fts));
        check({tag, ".fault_count"}, 64'(fault_count), 64'((m_events > 65535) ? 65535 : m_events));
        check({tag, ".sat_count"},   64'(s_count),     64'((m_events > 3) ? 3 : m_events));
        check({tag, ".overflow"},    64'(overflow),    64'(m_ovf));
        check({tag, ".rec_valid"},   64'(rec_valid),   64'(m_rv));
        check({tag, ".rec_ts"},      64'(rec_ts),      64'(m_rts));
        check({tag, ".rec_mask"},    64'(rec_mask),    64'(m_rmask));
    endtask

    typedef struct {
        logic [2:0] obs;
        logic       rdy;
        logic       clr;
        int         exp_count;
        logic       exp_flag;
        logic       exp_valid;
        logic [2:0] exp_mask;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // golden = 000 so obs equals the mismatch mask; expectations are after each edge.
        vecs[0]  = '{3'b001, 1'b0, 1'b0, 0, 1'b0, 1'b0, 3'b100, 1'b0};
        vecs[1]  = '{3'b011, 1'b0, 1'b0, 1, 1'b1, 1'b1, 3'b001, 1'b0};
        vecs[2]  = '{3'b000, 1'b0, 1'b0, 2, 1'b1, 1'b1, 3'b001, 1'b1};
        vecs[3]  = '{3'b010, 1'b0, 1'b0, 2, 1'b1, 1'b1, 3'b001, 1'b1};
        vecs[4]  = '{3'b010, 1'b0, 1'b0, 3, 1'b1, 1'b1, 3'b001, 1'b1};
        vecs[5]  = '{3'b010, 1'b1, 1'b0, 3, 1'b1, 1'b0, 3'b001, 1'b1};
        vecs[6]  = '{3'b010, 1'b0, 1'b0, 3, 1'b1, 1'b0, 3'b001, 1'b1};
        vecs[7]  = '{3'b010, 1'b0, 1'b1, 0, 1'b0, 1'b0, 3'b001, 1'b0};
        vecs[8]  = '{3'b110, 1'b0, 1'b0, 0, 1'b0, 1'b0, 3'b001, 1'b0};
        vecs[9]  = '{3'b110, 1'b0, 1'b1, 1, 1'b1, 1'b1, 3'b110, 1'b0};
        vecs[10] = '{3'b110, 1'b0, 1'b0, 1, 1'b1, 1'b1, 3'b110, 1'b0};

        reset_n = 1'b0; arm = 0; disarm = 0; clear = 0; rec_ready = 0;
        golden = 3'b101; obs = 3'b101;
        model_reset();
        #3;
        check_all("reset");
        #9;
        reset_n = 1'b1;

        // Steady state: matching pattern for 1000 cycles.
        arm = 1; tick(); arm = 0;
        repeat (1000) tick();
        check("steady.flag",  64'(fault_flag),  64'(0));
        check("steady.count", 64'(fault_count), 64'(0));
        check("steady.valid", 64'(rec_valid),   64'(0));
        check("steady.busy",  64'(busy),        64'(1));
        check_all("steady");

        // Single flip seen by obs_q in MONITOR cycle 20.
        arm = 1; tick(); arm = 0;
        repeat (27) tick();
        obs = 3'b100;
        repeat (2) tick();
        check("flip.count",    64'(fault_count), 64'(1));
        check("flip.fmask",    64'(first_mask),  64'(3'b001));
        check("flip.fts",      64'(first_ts),    64'(20));
        check("flip.valid",    64'(rec_valid),   64'(1));
        check("flip.rmask",    64'(rec_mask),    64'(3'b001));
        check("flip.rts",      64'(rec_ts),      64'(20));
        repeat (50) tick();
        check("flip.held_count", 64'(fault_count), 64'(1));
        check_all("flip");

        // Settle masking: mismatch during every settle cycle, then clean, then a flip.
        obs = 3'b000; arm = 1; clear = 1; rec_ready = 1;
        tick();
        arm = 0; clear = 0; rec_ready = 0;
        repeat (7) tick();
        obs = 3'b101;
        repeat (20) tick();
        check("settle.count", 64'(fault_count), 64'(0));
        check("settle.flag",  64'(fault_flag),  64'(0));
        obs = 3'b001;
        repeat (2) tick();
        check("settle.flip_count", 64'(fault_count), 64'(1));
        check("settle.flip_mask",  64'(first_mask),  64'(3'b100));
        check_all("settle");

        // Table: overflow and clear coinciding with an event.
        golden = 3'b000; obs = 3'b000; arm = 1; clear = 1; rec_ready = 1;
        tick();
        arm = 0; clear = 0;
        repeat (10) tick();
        for (int i = 0; i < 11; i++) begin
            obs = vecs[i].obs; rec_ready = vecs[i].rdy; clear = vecs[i].clr;
            tick();
            check($sformatf("vec%0d.count", i), 64'(fault_count), 64'(vecs[i].exp_count));
            check($sformatf("vec%0d.flag", i),  64'(fault_flag),  64'(vecs[i].exp_flag));
            check($sformatf("vec%0d.valid", i), 64'(rec_valid),   64'(vecs[i].exp_valid));
            check($sformatf("vec%0d.mask", i),  64'(rec_mask),    64'(vecs[i].exp_mask));
            check($sformatf("vec%0d.ovf", i),   64'(overflow),    64'(vecs[i].exp_ovf));
            if (i == 6) check("vec6.first_mask", 64'(first_mask), 64'(3'b001));
            if (i == 9) check("vec9.first_mask", 64'(first_mask), 64'(3'b110));
            check_all($sformatf("vec%0d", i));
        end
        clear = 0; rec_ready = 0;

        // Saturation: five distinct events on the 2-bit counter build.
        clear = 1; tick(); clear = 0;
        for (int i = 1; i <= 5; i++) begin
            obs = 3'(i);
            tick();
        end
        repeat (2) tick();
        check("sat.count16", 64'(fault_count), 64'(5));
        check("sat.count2",  64'(s_count),     64'(3));
        check_all("sat");

        // Asynchronous reset pulse mid-run while a record is pending.
        check("areset.pre_valid", 64'(rec_valid), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("areset.busy",  64'(busy),        64'(0));
        check("areset.count", 64'(fault_count), 64'(0));
        check("areset.valid", 64'(rec_valid),   64'(0));
        check_all("areset");
        #2 reset_n = 1'b1;
        repeat (20) tick();
        check("areset.idle_busy",  64'(busy),        64'(0));
        check("areset.idle_count", 64'(fault_count), 64'(0));
        golden = 3'b101; obs = 3'b101; arm = 1; tick(); arm = 0;
        repeat (12) tick();
        check("areset.resume_busy", 64'(busy), 64'(1));
        check_all("resume");

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            arm       = ($urandom_range(0, 99) < 3);
            disarm    = ($urandom_range(0, 99) < 1);
            clear     = ($urandom_range(0, 99) < 2);
            golden    = 3'($urandom_range(0, 7));
            rec_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 15) obs = 3'($urandom_range(0, 7));
            tick();
            check_all("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
